predecode_ras: RTL and testbench

PREDECODE_RAS -- requirements
Module: predecode_ras

---
 rtl/predecode_ras.sv | 216 +++++++++++++++++++++
 tb/tb_predecode_ras.sv | 327 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/predecode_ras.sv
// predecode_ras: fetch-stage predecoder for jal/jalr/branch with a circular
// return-address stack. Optional macro BHT_EN builds a table of 2-bit branch
// counters; without it branches use static backward-taken prediction.
module predecode_ras #(
  parameter int unsigned XLEN        = 32,
  parameter int unsigned RAS_DEPTH   = 4,
  parameter int unsigned BHT_ENTRIES = 64
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            if_valid,
  input  logic            if_stall,
  input  logic [XLEN-1:0] if_pc,
  input  logic [31:0]     if_instr,
  input  logic [XLEN-1:0] rs1_val,
  input  logic            dec_rd_wen,
  input  logic [4:0]      dec_rd,
  input  logic            ex_flush,
  input  logic            ex_bxx_valid,
  input  logic [XLEN-1:0] ex_bxx_pc,
  input  logic            ex_bxx_taken,
  output logic            pred_valid,
  output logic            pred_taken,
  output logic [XLEN-1:0] pred_target,
  output logic            pred_is_ret,
  output logic            jalr_dep,
  output logic            ras_empty,
  output logic            ras_full
);

  localparam int unsigned PTR_W = $clog2(RAS_DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  localparam logic [6:0] OP_JAL  = 7'b1101111;
  localparam logic [6:0] OP_JALR = 7'b1100111;
  localparam logic [6:0] OP_BR   = 7'b1100011;

  logic [4:0]      rd;
  logic [4:0]      rs1;
  logic            is_jal;
  logic            is_jalr;
  logic            is_br;
  logic            rd_link;
  logic            rs1_link;
  logic            is_call;
  logic            is_ret;
  logic            is_swap;
  logic            ras_hit;
  logic            fire;
  logic            br_taken;
  logic [XLEN-1:0] imm_j;
  logic [XLEN-1:0] imm_b;
  logic [XLEN-1:0] imm_i;
  logic [XLEN-1:0] link_addr;
  logic [XLEN-1:0] jalr_sum;
  logic [XLEN-1:0] ras_top;

  logic [XLEN-1:0]  ras_q [RAS_DEPTH];
  logic [XLEN-1:0]  ras_d [RAS_DEPTH];
  logic [PTR_W-1:0] tos_q;
  logic [PTR_W-1:0] tos_d;
  logic [PTR_W-1:0] tos_inc;
  logic [PTR_W-1:0] tos_dec;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Instruction class and immediate decode
  assign rd      = if_instr[11:7];
  assign rs1     = if_instr[19:15];
  assign is_jal  = (if_instr[6:0] == OP_JAL);
  assign is_jalr = (if_instr[6:0] == OP_JALR);
  assign is_br   = (if_instr[6:0] == OP_BR);

  assign imm_j = {{(XLEN-20){if_instr[31]}}, if_instr[19:12], if_instr[20],
                  if_instr[30:21], 1'b0};
  assign imm_b = {{(XLEN-12){if_instr[31]}}, if_instr[7], if_instr[30:25],
                  if_instr[11:8], 1'b0};
  assign imm_i = {{(XLEN-11){if_instr[31]}}, if_instr[30:20]};

  // x1 and x5 are the link registers for call/return hinting
  assign rd_link  = (rd == 5'd1) || (rd == 5'd5);
  assign rs1_link = (rs1 == 5'd1) || (rs1 == 5'd5);
  assign is_call  = (is_jal || is_jalr) && rd_link;
  assign is_ret   = is_jalr && rs1_link && (rd == 5'd0);
  assign is_swap  = is_jalr && rd_link && rs1_link && (rd != rs1);
  assign ras_hit  = is_ret && (cnt_q != '0);

  assign link_addr = if_pc + XLEN'(4);
  assign jalr_sum  = rs1_val + imm_i;
  assign ras_top   = ras_q[tos_q];
  assign tos_inc   = tos_q + PTR_W'(1);
  assign tos_dec   = tos_q - PTR_W'(1);

  // A ret served from the RAS never needs rs1, so it never stalls
  assign jalr_dep = if_valid && is_jalr && dec_rd_wen && (dec_rd == rs1) &&
                    (rs1 != 5'd0) && !ras_hit;

  assign pred_valid = if_valid && !ex_flush && !jalr_dep && (is_jal || is_jalr || is_br);
  assign fire       = if_valid && !if_stall && !jalr_dep && !ex_flush;

  assign ras_empty = (cnt_q == '0);
  assign ras_full  = (cnt_q == CNT_W'(RAS_DEPTH));

  // Prediction: direction, target and RAS-source flag
  always_comb begin
    pred_taken  = 1'b0;
    pred_is_ret = 1'b0;
    pred_target = link_addr;
    if (is_jal) begin
      pred_taken  = 1'b1;
      pred_target = if_pc + imm_j;
    end else if (is_jalr) begin
      pred_taken = 1'b1;
      if (ras_hit) begin
        pred_is_ret = 1'b1;
        pred_target = ras_top;
      end else begin
        pred_target = {jalr_sum[XLEN-1:1], 1'b0};
      end
    end else if (is_br) begin
      pred_taken = br_taken;
      if (br_taken) begin
        pred_target = if_pc + imm_b;
      end
    end
    if (!pred_valid) begin
      pred_taken  = 1'b0;
      pred_is_ret = 1'b0;
    end
  end

  // RAS next state: flush clears count, otherwise swap / push / pop on fire
  always_comb begin
    ras_d = ras_q;
    tos_d = tos_q;
    cnt_d = cnt_q;
    if (ex_flush) begin
      cnt_d = '0;
    end else if (fire) begin
      if (is_swap && (cnt_q != '0)) begin
        ras_d[tos_q] = link_addr;
      end else if (is_call) begin
        tos_d          = tos_inc;
        ras_d[tos_inc] = link_addr;
        if (cnt_q != CNT_W'(RAS_DEPTH)) begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end else if (is_ret && (cnt_q != '0)) begin
        tos_d = tos_dec;
        cnt_d = cnt_q - CNT_W'(1);
      end
    end
  end

  // RAS state registers
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < int'(RAS_DEPTH); i++) begin
        ras_q[i] <= '0;
      end
      tos_q <= '0;
      cnt_q <= '0;
    end else begin
      ras_q <= ras_d;
      tos_q <= tos_d;
      cnt_q <= cnt_d;
    end
  end

`ifdef BHT_EN
  localparam int unsigned BHT_W = $clog2(BHT_ENTRIES);

  logic [1:0]       bht_q [BHT_ENTRIES];
  logic [1:0]       bht_d [BHT_ENTRIES];
  logic [BHT_W-1:0] bht_rd_idx;
  logic [BHT_W-1:0] bht_wr_idx;
  logic [1:0]       bht_old;
  logic             unused_bits;

  assign bht_rd_idx  = if_pc[BHT_W+1:2];
  assign bht_wr_idx  = ex_bxx_pc[BHT_W+1:2];
  assign bht_old     = bht_q[bht_wr_idx];
  assign br_taken    = bht_q[bht_rd_idx][1];
  assign unused_bits = ^{ex_bxx_pc[XLEN-1:BHT_W+2], ex_bxx_pc[1:0]};

  // Saturating counter update from resolved branches
  always_comb begin
    bht_d = bht_q;
    if (ex_bxx_valid) begin
      if (ex_bxx_taken && (bht_old != 2'b11)) begin
        bht_d[bht_wr_idx] = bht_old + 2'd1;
      end else if (!ex_bxx_taken && (bht_old != 2'b00)) begin
        bht_d[bht_wr_idx] = bht_old - 2'd1;
      end
    end
  end

  // BHT registers, weakly not-taken after reset
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < int'(BHT_ENTRIES); i++) begin
        bht_q[i] <= 2'b01;
      end
    end else begin
      bht_q <= bht_d;
    end
  end
`else
  logic unused_bits;

  // Static prediction: backward branches taken
  assign br_taken    = imm_b[XLEN-1];
  assign unused_bits = ^{ex_bxx_valid, ex_bxx_pc, ex_bxx_taken, 32'(BHT_ENTRIES)};
`endif

endmodule

// File: tb/tb_predecode_ras.sv
// tb_predecode_ras: table-driven predecode checks plus RAS/BHT sequences.
module tb_predecode_ras;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_valid;
  logic        if_stall;
  logic [31:0] if_pc;
  logic [31:0] if_instr;
  logic [31:0] rs1_val;
  logic        dec_rd_wen;
  logic [4:0]  dec_rd;
  logic        ex_flush;
  logic        ex_bxx_valid;
  logic [31:0] ex_bxx_pc;
  logic        ex_bxx_taken;
  logic        pred_valid;
  logic        pred_taken;
  logic [31:0] pred_target;
  logic        pred_is_ret;
  logic        jalr_dep;
  logic        ras_empty;
  logic        ras_full;

  int n_total = 0;
  int n_pass  = 0;

  always #5 clk = ~clk;

  predecode_ras dut (
    .clk          (clk),
    .rst          (rst),
    .if_valid     (if_valid),
    .if_stall     (if_stall),
    .if_pc        (if_pc),
    .if_instr     (if_instr),
    .rs1_val      (rs1_val),
    .dec_rd_wen   (dec_rd_wen),
    .dec_rd       (dec_rd),
    .ex_flush     (ex_flush),
    .ex_bxx_valid (ex_bxx_valid),
    .ex_bxx_pc    (ex_bxx_pc),
    .ex_bxx_taken (ex_bxx_taken),
    .pred_valid   (pred_valid),
    .pred_taken   (pred_taken),
    .pred_target  (pred_target),
    .pred_is_ret  (pred_is_ret),
    .jalr_dep     (jalr_dep),
    .ras_empty    (ras_empty),
    .ras_full     (ras_full)
  );

  typedef struct packed {
    logic        v;
    logic [31:0] pc;
    logic [31:0] ins;
    logic [31:0] r1;
    logic        wen;
    logic [4:0]  drd;
    logic        fl;
    logic        e_valid;
    logic        e_taken;
    logic        e_ret;
    logic        e_dep;
    logic [31:0] e_tgt;
  } vec_t;

  localparam int NV = 16;
  vec_t vecs [NV];

  function automatic logic [31:0] enc_jal(input logic [4:0] rd, input int imm);
    logic [20:0] m;
    m = imm[20:0];
    return {m[20], m[10:1], m[11], m[19:12], rd, 7'b1101111};
  endfunction

  function automatic logic [31:0] enc_jalr(input logic [4:0] rd, input logic [4:0] rs1, input int imm);
    logic [11:0] m;
    m = imm[11:0];
    return {m, rs1, 3'b000, rd, 7'b1100111};
  endfunction

  function automatic logic [31:0] enc_br(input int imm);
    logic [12:0] m;
    m = imm[12:0];
    return {m[12], m[10:5], 5'd0, 5'd0, 3'b000, m[4:1], m[11], 7'b1100011};
  endfunction

  function automatic vec_t mk(input logic v, input logic [31:0] pc, input logic [31:0] ins,
                              input logic [31:0] r1, input logic wen, input logic [4:0] drd,
                              input logic fl, input logic ev, input logic et, input logic er,
                              input logic ed, input logic [31:0] etgt);
    vec_t t;
    t.v = v; t.pc = pc; t.ins = ins; t.r1 = r1; t.wen = wen; t.drd = drd; t.fl = fl;
    t.e_valid = ev; t.e_taken = et; t.e_ret = er; t.e_dep = ed; t.e_tgt = etgt;
    return t;
  endfunction

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", nm, got, exp);
  endtask

  task automatic drive(input logic v, input logic st, input logic [31:0] pc, input logic [31:0] ins,
                       input logic [31:0] r1, input logic wen, input logic [4:0] drd, input logic fl);
    if_valid = v; if_stall = st; if_pc = pc; if_instr = ins;
    rs1_val = r1; dec_rd_wen = wen; dec_rd = drd; ex_flush = fl;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 32'h0, 32'h0000_0013, 32'h0, 1'b0, 5'd0, 1'b0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    idle();
    ex_bxx_valid = 1'b0; ex_bxx_pc = 32'h0; ex_bxx_taken = 1'b0;
    step();
    step();
    rst = 1'b0;
  endtask

  // Firing call (jal x1) at pc; pushes pc+4
  task automatic do_call(input logic [31:0] pc);
    drive(1'b1, 1'b0, pc, enc_jal(5'd1, 32'h40), 32'h0, 1'b0, 5'd0, 1'b0);
    @(negedge clk);
    step();
  endtask

  // ret (jalr x0, x1, 0); stall=1 peeks without popping
  task automatic do_ret(input string nm, input logic st, input logic [31:0] r1, input logic wen,
                        input logic [4:0] drd, input logic e_ret, input logic [31:0] e_tgt);
    drive(1'b1, st, 32'h700, enc_jalr(5'd0, 5'd1, 0), r1, wen, drd, 1'b0);
    @(negedge clk);
    chk({nm, "_valid"}, pred_valid, 1);
    chk({nm, "_dep"}, jalr_dep, 0);
    chk({nm, "_is_ret"}, pred_is_ret, e_ret);
    chk({nm, "_tgt"}, pred_target, e_tgt);
    step();
  endtask

  task automatic chk_flags(input string nm, input logic e_empty, input logic e_full);
    idle();
    @(negedge clk);
    chk({nm, "_empty"}, ras_empty, e_empty);
    chk({nm, "_full"}, ras_full, e_full);
    step();
  endtask

  task automatic chk_br(input string nm, input logic [31:0] pc, input int imm,
                        input logic e_taken, input logic [31:0] e_tgt);
    drive(1'b1, 1'b1, pc, enc_br(imm), 32'h0, 1'b0, 5'd0, 1'b0);
    @(negedge clk);
    chk({nm, "_taken"}, pred_taken, e_taken);
    chk({nm, "_tgt"}, pred_target, e_tgt);
  endtask

  initial begin
    vecs[0]  = mk(0, 32'h100,  enc_jal(5'd1, 32'h20),      32'h0,    0, 5'd0, 0, 0, 0, 0, 0, 32'h0);
    vecs[1]  = mk(1, 32'h100,  enc_jal(5'd1, 32'h20),      32'h0,    0, 5'd0, 0, 1, 1, 0, 0, 32'h120);
    vecs[2]  = mk(1, 32'h1000, enc_jal(5'd0, -256),        32'h0,    0, 5'd0, 0, 1, 1, 0, 0, 32'hF00);
    vecs[3]  = mk(1, 32'h2000, enc_jalr(5'd0, 5'd6, 16),   32'h2001, 0, 5'd0, 0, 1, 1, 0, 0, 32'h2010);
    vecs[4]  = mk(1, 32'h2000, enc_jalr(5'd1, 5'd10, -4),  32'h3000, 0, 5'd0, 0, 1, 1, 0, 0, 32'h2FFC);
    vecs[5]  = mk(1, 32'h2000, enc_jalr(5'd0, 5'd1, 0),    32'h4445, 0, 5'd0, 0, 1, 1, 0, 0, 32'h4444);
    vecs[6]  = mk(1, 32'h2000, enc_jalr(5'd0, 5'd7, 8),    32'h501,  1, 5'd7, 0, 0, 0, 0, 1, 32'h0);
    vecs[7]  = mk(1, 32'h2000, enc_jalr(5'd0, 5'd7, 8),    32'h501,  1, 5'd8, 0, 1, 1, 0, 0, 32'h508);
    vecs[8]  = mk(1, 32'h2000, enc_jalr(5'd0, 5'd0, 64),   32'h0,    1, 5'd0, 0, 1, 1, 0, 0, 32'h40);
`ifdef BHT_EN
    vecs[9]  = mk(1, 32'h300,  enc_br(-8),                 32'h0,    0, 5'd0, 0, 1, 0, 0, 0, 32'h304);
`else
    vecs[9]  = mk(1, 32'h300,  enc_br(-8),                 32'h0,    0, 5'd0, 0, 1, 1, 0, 0, 32'h2F8);
`endif
    vecs[10] = mk(1, 32'h300,  enc_br(8),                  32'h0,    0, 5'd0, 0, 1, 0, 0, 0, 32'h304);
    vecs[11] = mk(1, 32'h400,  32'h0000_0013,              32'h0,    0, 5'd0, 0, 0, 0, 0, 0, 32'h0);
    vecs[12] = mk(1, 32'h100,  enc_jal(5'd1, 32'h20),      32'h0,    0, 5'd0, 1, 0, 0, 0, 0, 32'h0);
    vecs[13] = mk(1, 32'h2000, enc_jalr(5'd0, 5'd7, 8),    32'h501,  0, 5'd7, 0, 1, 1, 0, 0, 32'h508);
    vecs[14] = mk(0, 32'h300,  enc_br(-8),                 32'h0,    0, 5'd0, 0, 0, 0, 0, 0, 32'h0);
    vecs[15] = mk(1, 32'h100,  enc_jal(5'd1, 32'h8000),    32'h0,    1, 5'd1, 0, 1, 1, 0, 0, 32'h8100);

    do_reset();

    // Reset state
    @(negedge clk);
    chk("rst_empty", ras_empty, 1);
    chk("rst_full", ras_full, 0);
    chk("rst_is_ret", pred_is_ret, 0);
    chk("rst_valid", pred_valid, 0);
    step();

    // Single-cycle decode table, stalled so RAS stays empty
    for (int i = 0; i < NV; i++) begin
      drive(vecs[i].v, 1'b1, vecs[i].pc, vecs[i].ins, vecs[i].r1, vecs[i].wen, vecs[i].drd, vecs[i].fl);
      @(negedge clk);
      chk($sformatf("vec%0d_valid", i), pred_valid, vecs[i].e_valid);
      chk($sformatf("vec%0d_taken", i), pred_taken, vecs[i].e_taken);
      chk($sformatf("vec%0d_is_ret", i), pred_is_ret, vecs[i].e_ret);
      chk($sformatf("vec%0d_dep", i), jalr_dep, vecs[i].e_dep);
      if (vecs[i].e_valid) chk($sformatf("vec%0d_tgt", i), pred_target, vecs[i].e_tgt);
      step();
    end
    chk_flags("tbl_end", 1, 0);

    // jal call at 0x100 pushes 0x104
    drive(1'b1, 1'b0, 32'h100, enc_jal(5'd1, 32'h20), 32'h0, 1'b0, 5'd0, 1'b0);
    @(negedge clk);
    chk("call_taken", pred_taken, 1);
    chk("call_tgt", pred_target, 32'h120);
    step();
    chk_flags("call", 0, 0);
    do_ret("peek104", 1'b1, 32'hDEAD_0000, 1'b0, 5'd0, 1, 32'h104);
    do_ret("pop104", 1'b0, 32'hDEAD_0000, 1'b0, 5'd0, 1, 32'h104);
    chk_flags("pop104", 1, 0);

    // Five calls overflow a 4-deep RAS; oldest entry lost
    for (int k = 1; k <= 4; k++) do_call(32'(k * 16));
    chk_flags("four_calls", 0, 1);
    do_call(32'h50);
    chk_flags("five_calls", 0, 1);
    do_ret("ret1", 1'b0, 32'h999, 1'b1, 5'd1, 1, 32'h54);
    do_ret("ret2", 1'b0, 32'h999, 1'b0, 5'd0, 1, 32'h44);
    do_ret("ret3", 1'b0, 32'h999, 1'b0, 5'd0, 1, 32'h34);
    do_ret("ret4", 1'b0, 32'h999, 1'b0, 5'd0, 1, 32'h24);
    do_ret("ret5", 1'b0, 32'h999, 1'b0, 5'd0, 0, 32'h998);
    chk_flags("ret5", 1, 0);

    // Dependent jalr call is held off and must not push
    do_call(32'h600);
    drive(1'b1, 1'b0, 32'h700, enc_jalr(5'd1, 5'd7, 0), 32'h1234, 1'b1, 5'd7, 1'b0);
    @(negedge clk);
    chk("dep_call_dep", jalr_dep, 1);
    chk("dep_call_valid", pred_valid, 0);
    step();
    do_ret("dep_peek", 1'b1, 32'h0, 1'b0, 5'd0, 1, 32'h604);
    do_ret("dep_pop", 1'b0, 32'h0, 1'b0, 5'd0, 1, 32'h604);
    chk_flags("dep_pop", 1, 0);

    // jalr x1, x5 replaces top without changing count
    do_call(32'h10);
    do_call(32'h20);
    drive(1'b1, 1'b0, 32'h80, enc_jalr(5'd1, 5'd5, 0), 32'h5000, 1'b0, 5'd0, 1'b0);
    @(negedge clk);
    chk("swap_tgt", pred_target, 32'h5000);
    chk("swap_is_ret", pred_is_ret, 0);
    step();
    do_ret("swap_r1", 1'b0, 32'h0, 1'b0, 5'd0, 1, 32'h84);
    do_ret("swap_r2", 1'b0, 32'h0, 1'b0, 5'd0, 1, 32'h14);
    chk_flags("swap_end", 1, 0);

    // Flush beats a same-cycle call
    do_call(32'h10);
    do_call(32'h20);
    drive(1'b1, 1'b0, 32'h30, enc_jal(5'd1, 32'h40), 32'h0, 1'b0, 5'd0, 1'b1);
    @(negedge clk);
    chk("flush_valid", pred_valid, 0);
    step();
    chk_flags("flush", 1, 0);
    do_ret("flush_ret", 1'b1, 32'h100, 1'b0, 5'd0, 0, 32'h100);

    // Stalled call does not push
    drive(1'b1, 1'b1, 32'h900, enc_jal(5'd1, 32'h40), 32'h0, 1'b0, 5'd0, 1'b0);
    step();
    chk_flags("stall", 1, 0);

    // Reset overrides a same-cycle fire
    do_call(32'h10);
    rst = 1'b1;
    drive(1'b1, 1'b0, 32'h20, enc_jal(5'd1, 32'h40), 32'h0, 1'b0, 5'd0, 1'b0);
    step();
    rst = 1'b0;
    chk_flags("rst_mid", 1, 0);

`ifdef BHT_EN
    // Two taken updates train 0x200 to taken
    ex_bxx_valid = 1'b1; ex_bxx_pc = 32'h200; ex_bxx_taken = 1'b1;
    step();
    step();
    ex_bxx_valid = 1'b0;
    chk_br("bht_200", 32'h200, 8, 1, 32'h208);
    step();
    // Same-index read during update sees the old counter
    ex_bxx_valid = 1'b1; ex_bxx_pc = 32'h240; ex_bxx_taken = 1'b1;
    chk_br("bht_same", 32'h240, 8, 0, 32'h244);
    step();
    ex_bxx_valid = 1'b0;
    chk_br("bht_after", 32'h240, 8, 1, 32'h248);
    step();
    // Decrement saturates at zero
    ex_bxx_valid = 1'b1; ex_bxx_taken = 1'b0;
    step(); step(); step();
    ex_bxx_taken = 1'b1;
    step();
    ex_bxx_valid = 1'b0;
    chk_br("bht_sat0", 32'h240, 8, 0, 32'h244);
    step();
    // Reset overrides a same-cycle counter update
    rst = 1'b1;
    ex_bxx_valid = 1'b1; ex_bxx_pc = 32'h280; ex_bxx_taken = 1'b1;
    step();
    rst = 1'b0;
    ex_bxx_valid = 1'b0;
    chk_br("bht_rst", 32'h280, 8, 0, 32'h284);
    step();
`else
    // Resolved-branch updates have no effect on static prediction
    ex_bxx_valid = 1'b1; ex_bxx_pc = 32'h300; ex_bxx_taken = 1'b1;
    step();
    step();
    ex_bxx_valid = 1'b0;
    chk_br("static_fwd", 32'h300, 8, 0, 32'h304);
    step();
    chk_br("static_bwd", 32'h300, -8, 1, 32'h2F8);
    step();
`endif

    idle();
    step();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
